// File: rtl/mont_mul_engine.sv
// Radix-2 bit-serial Montgomery multiplier: result = x*y*2^-WIDTH mod n.
// Responder side of the mul_start/mul_finish/mul_rst controller handshake.
module mont_mul_engine #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             mul_rst,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             mul_finish,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] ns_q, ns_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             fin_q, fin_d;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] ns_ext;

  assign ns_ext = {2'b00, ns_q};

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    ns_d    = ns_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    fin_d   = fin_q;
    // t < 4n, so two guard bits keep the sum exact
    t = acc_q + (xs_q[idx_q[IW-2:0]] ? {2'b00, ys_q} : '0);
    if (t[0]) t = t + ns_ext;
    unique case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          xs_d    = x;
          ys_d    = y;
          ns_d    = n;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = t >> 1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(WIDTH - 1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        if (acc_q >= ns_ext) res_d = WIDTH'(acc_q - ns_ext);
        else                 res_d = acc_q[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (mul_start) begin
          fin_d = 1'b1;
        end else begin
          fin_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst || mul_rst) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      ns_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      ns_q    <= ns_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
    end
  end

  assign result     = res_q;
  assign mul_finish = fin_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_FINAL);

endmodule

// File: tb/tb_mont_mul_engine.sv
// Directed and randomized checks of mont_mul_engine at WIDTH=8 (R=256).
// Expected products come from a brute-force modular-inverse model.
module tb_mont_mul_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         sys_rst, mul_rst, mul_start;
  logic [W-1:0] x, y, n;
  logic [W-1:0] result;
  logic         mul_finish, busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int n;
    int x;
    int y;
    int exp;
  } vec_t;

  vec_t tbl[4];

  mont_mul_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .mul_rst   (mul_rst),
    .mul_start (mul_start),
    .x         (x),
    .y         (y),
    .n         (n),
    .result    (result),
    .mul_finish(mul_finish),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // r such that r*256 == x*y (mod n)
  function automatic int ref_mm(input int nn, input int xx, input int yy);
    int p;
    p = (xx * yy) % nn;
    for (int r = 0; r < nn; r++)
      if (((r * 256) % nn) == p) return r;
    return -1;
  endfunction

  // Launch and wait for mul_finish; start is left high.
  task automatic run_op(input int nn, input int xx, input int yy,
                        output int lat, output int res);
    n = W'(nn);
    x = W'(xx);
    y = W'(yy);
    mul_start = 1'b1;
    tick();
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mul_finish) begin
        lat = c;
        break;
      end
    end
    res = int'(result);
  endtask

  task automatic wait_fin(output int ok);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mul_finish) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, res, bad, ok, rn, rx, ry;
    tbl[0] = '{13, 5, 7, 1};
    tbl[1] = '{251, 250, 250, 201};
    tbl[2] = '{13, 12, 12, 3};
    tbl[3] = '{13, 9, 1, 1};

    sys_rst = 1'b1;
    mul_rst = 1'b0;
    mul_start = 1'b0;
    x = '0;
    y = '0;
    n = '0;
    tick();
    tick();
    chk("rst_result", int'(result), 0);
    chk("rst_finish", int'(mul_finish), 0);
    chk("rst_busy", int'(busy), 0);
    sys_rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].n, tbl[i].x, tbl[i].y, lat, res);
      chk($sformatf("tbl%0d_lat", i), lat, 10);
      chk($sformatf("tbl%0d_res", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
      mul_start = 1'b0;
      tick();
      chk($sformatf("tbl%0d_fin_drop", i), int'(mul_finish), 0);
      chk($sformatf("tbl%0d_res_hold", i), int'(result), tbl[i].exp);
    end

    // soft reset mid-run aborts and clears result
    n = 8'd13;
    x = 8'd5;
    y = 8'd7;
    mul_start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("abort_busy_before", int'(busy), 1);
    mul_rst = 1'b1;
    mul_start = 1'b0;
    tick();
    mul_rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_finish", int'(mul_finish), 0);
    chk("abort_result", int'(result), 0);
    tick();
    chk("abort_idle", int'(busy), 0);
    run_op(13, 5, 7, lat, res);
    chk("relaunch_lat", lat, 10);
    chk("relaunch_res", res, 1);
    mul_start = 1'b0;
    tick();

    // start held in DONE must not relaunch
    run_op(13, 0, 12, lat, res);
    chk("zero_res", res, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy || !mul_finish || result != 0) bad++;
    end
    chk("done_hold", bad, 0);
    mul_start = 1'b0;
    tick();

    // operand changes and start toggling mid-run are ignored
    n = 8'd13;
    x = 8'd5;
    y = 8'd7;
    mul_start = 1'b1;
    tick();
    tick();
    tick();
    n = 8'd251;
    x = 8'd200;
    y = 8'd100;
    mul_start = 1'b0;
    tick();
    tick();
    mul_start = 1'b1;
    wait_fin(ok);
    chk("midrun_done", ok, 1);
    chk("midrun_res", int'(result), 1);
    mul_start = 1'b0;
    tick();

    // sys_rst together with start: no launch that cycle
    n = 8'd251;
    x = 8'd250;
    y = 8'd250;
    sys_rst = 1'b1;
    mul_start = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst_start_busy", int'(busy), 0);
    chk("rst_start_res", int'(result), 0);
    tick();
    chk("post_rst_launch", int'(busy), 1);
    wait_fin(ok);
    chk("post_rst_done", ok, 1);
    chk("post_rst_res", int'(result), 201);
    mul_start = 1'b0;
    tick();

    for (int i = 0; i < 1000; i++) begin
      rn = 2 * $urandom_range(1, 127) + 1;
      rx = $urandom_range(0, rn - 1);
      ry = $urandom_range(0, rn - 1);
      run_op(rn, rx, ry, lat, res);
      n_cmp++;
      if (lat != 10 || res != ref_mm(rn, rx, ry)) begin
        n_bad++;
        $display("FAIL rand n=%0d x=%0d y=%0d: got %0d lat %0d expected %0d lat 10",
                 rn, rx, ry, res, lat, ref_mm(rn, rx, ry));
      end
      mul_start = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
